inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the single-cycle MIPS datapath
//  fetch port (PC -> instruction) and a slow instruction memory with per-word req/ack.
//  Hits return the instruction combinationally in the same cycle.
//  Misses deassert cpu_ready; the top level uses it to hold the PC.
//  The cache then refills one full line as a burst of word handshakes.
// PARAMETERS
//  LINES           16  number of cache lines (power of 2, >=2)
//  WORDS_PER_LINE  4   32-bit words per line (power of 2, >=2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  cpu_adr    in   32  fetch byte address (PC); bits [1:0] ignored
//  cpu_inst   out  32  instruction word; 32'd0 when cpu_ready=0
//  cpu_ready  out  1   1 = hit, cpu_inst valid this cycle
//  flush      in   1   synchronous invalidate-all request
//  mem_req    out  1   refill word request to instruction memory
//  mem_adr    out  32  word-aligned refill address ([1:0]=2'b00)
//  mem_rdata  in   32  refill data, valid when mem_ack=1
//  mem_ack    in   1   word accepted/returned this cycle
// BEHAVIOUR
//  - Address split: OFS = cpu_adr[WO+1:2], IDX = next log2(LINES) bits, TAG = remaining upper bits.
//    WO = log2(WORDS_PER_LINE).
//  - Storage: data[LINES][WORDS_PER_LINE], tag[LINES], valid[LINES].
//  - Reset (rst=0, async): valid all 0, state IDLE, word counter 0, mem_req=0, mem_adr=0,
//    pending flush cleared; hence cpu_ready=0 and cpu_inst=0. Data/tag arrays are not reset.
//  - FSM IDLE:
//    - hit = valid[IDX] && tag[IDX]==TAG. cpu_ready=hit, cpu_inst=data[IDX][OFS], zero latency.
//    - On miss with flush=0: latch line base address {TAG,IDX,0...} and go to REFILL.
//      mem_req=1 and mem_adr=base from the next cycle.
//    - flush=1 in IDLE: clear all valid at the edge; no refill is started that cycle.
//  - FSM REFILL:
//    - cpu_ready=0.
//    - mem_req=1; mem_adr=base+4*cnt, held stable until mem_ack.
//    - On mem_ack: data[line][cnt]<=mem_rdata, cnt++.
//    - Ack on the last word (cnt=WORDS_PER_LINE-1): write tag, set valid, cnt<=0, mem_req<=0,
//      go to IDLE. The next cycle hits if cpu_adr is unchanged (miss penalty = WORDS_PER_LINE
//      ack cycles + 1).
//    - cpu_adr changes during REFILL are ignored; the latched line always completes.
//    - mem_ack while mem_req=0 is ignored.
//    - flush during REFILL is latched as pending. At refill end, all valid bits are cleared
//      and the just-filled line is NOT marked valid. Pending flush then clears.
//    - flush held across the last-ack edge behaves the same.
//  - Reset mid-REFILL: the partial line stays invalid and mem_req drops immediately.
//  - The cache never writes to memory. There is no self-modifying-code coherence;
//    software uses flush.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds ports hit_cnt out 32 and miss_cnt out 32.
//  - hit_cnt increments on every clock edge with state IDLE and cpu_ready=1.
//  - miss_cnt increments on each IDLE->REFILL transition.
//  - Both counters saturate at 32'hFFFF_FFFF, reset to 0, and are also cleared by flush.
//  ICACHE_STATS_EN undefined: ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. Reset, cpu_adr=0x0000_0040 -> cpu_ready=0. Next cycle: mem_req=1, mem_adr=0x40, 0x44, 0x48, 0x4C
//     on successive acks. Data 0xA0..0xA3 -> then cpu_ready=1, cpu_inst=0xA0; adr 0x4C -> 0xA3.
//  2. Memory acks every 3rd cycle -> mem_adr/mem_req stable while waiting. Fill completes after
//     4 acks; no word is written without ack.
//  3. Conflict: line at 0x40 filled, then cpu_adr=0x140 (same IDX, different TAG) -> miss, refill
//     from 0x140. Returning to 0x40 -> miss again.
//  4. Change cpu_adr to 0x80 at the 2nd ack of a 0x40 refill -> refill of 0x40..0x4C completes.
//     Then IDLE misses on 0x80 and a new refill starts at 0x80.
//  5. flush pulse during 3rd ack of refill -> after final ack cpu_ready=0 for same adr and a new
//     refill starts. A flush pulse in IDLE after filling 0x40 -> next access to 0x40 misses.
//  6. ICACHE_STATS_EN: sequence 0x40 (miss), 8 hit cycles, 0x140 (miss) -> miss_cnt=2,
//     hit_cnt=9 (8 + post-refill hit). Async rst=0 mid-refill -> mem_req=0 immediately and
//     counters 0.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with zero-latency hits and per-word burst refill.
// Optional ICACHE_STATS_EN macro adds saturating hit_cnt/miss_cnt ports.
module inst_cache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_adr,
    output logic [31:0] cpu_inst,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_adr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WO = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - WO - IW;
    localparam logic [WO-1:0] LAST = WO'(WORDS_PER_LINE - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t          state;
    logic [WO-1:0]   cnt;
    logic [IW-1:0]   fill_idx;
    logic [TW-1:0]   fill_tag;
    logic            flush_pending;
    logic [LINES-1:0] valid;

    logic [31:0]     data_mem [LINES][WORDS_PER_LINE];
    logic [TW-1:0]   tag_mem  [LINES];

    logic [WO-1:0]   ofs;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic            hit;
    logic            word_ack;
    logic            last_ack;

    assign ofs = cpu_adr[WO+1:2];
    assign idx = cpu_adr[WO+IW+1:WO+2];
    assign tag = cpu_adr[31:WO+IW+2];

    assign hit       = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
    assign cpu_ready = hit;
    assign cpu_inst  = hit ? data_mem[idx][ofs] : 32'd0;

    // Acks are only meaningful while a word request is outstanding.
    assign word_ack = (state == REFILL) && mem_req && mem_ack;
    assign last_ack = word_ack && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            fill_idx      <= '0;
            fill_tag      <= '0;
            flush_pending <= 1'b0;
            valid         <= '0;
            mem_req       <= 1'b0;
            mem_adr       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (!hit) begin
                        fill_idx <= idx;
                        fill_tag <= tag;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_adr  <= {cpu_adr[31:WO+2], {(WO+2){1'b0}}};
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (word_ack) begin
                        if (cnt == LAST) begin
                            // A flush seen at any point during the fill discards the new line too.
                            if (flush || flush_pending) begin
                                valid <= '0;
                            end else begin
                                valid[fill_idx] <= 1'b1;
                            end
                            flush_pending <= 1'b0;
                            cnt           <= '0;
                            mem_req       <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            mem_adr <= mem_adr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide whether they are trusted.
    always_ff @(posedge clk) begin
        if (word_ack) begin
            data_mem[fill_idx][cnt] <= mem_rdata;
        end
        if (last_ack) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic miss_event;

    assign miss_event = (state == IDLE) && !hit && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (flush) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_event && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache; memory returns 0x90 + (word address).
// Define ICACHE_STATS_EN to also check the hit/miss counters.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_inst;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    inst_cache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_adr   (cpu_adr),
        .cpu_inst  (cpu_inst),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_adr   (mem_adr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h90 + (a >> 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic fl);
        cpu_adr = adr;
        flush   = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic checkHit(input logic [31:0] adr, input logic [31:0] expected);
        applyStimulus(adr, 1'b0);
        checkOutput("hit_ready", {31'd0, cpu_ready}, 32'd1);
        checkOutput("hit_inst", cpu_inst, expected);
    endtask

    task automatic checkMiss(input logic [31:0] adr);
        applyStimulus(adr, 1'b0);
        checkOutput("miss_ready", {31'd0, cpu_ready}, 32'd0);
        checkOutput("miss_inst", cpu_inst, 32'd0);
    endtask

    // Serves one full line; gap idle cycles precede each ack, optional address change / flush at a word.
    task automatic serveRefill(input logic [31:0] base, input int gap, input int chg_at,
                               input logic [31:0] chg_adr, input int flush_at);
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                checkOutput("wait_req", {31'd0, mem_req}, 32'd1);
                checkOutput("wait_adr", mem_adr, base + 32'(4 * w));
                tick();
            end
            if (w == chg_at) cpu_adr = chg_adr;
            flush = (w == flush_at);
            #1;
            checkOutput("refill_req", {31'd0, mem_req}, 32'd1);
            checkOutput("refill_adr", mem_adr, base + 32'(4 * w));
            checkOutput("refill_ready", {31'd0, cpu_ready}, 32'd0);
            mem_ack   = 1'b1;
            mem_rdata = mem_word(base + 32'(4 * w));
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            flush     = 1'b0;
        end
        checkOutput("refill_done_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        cpu_adr   = 32'h40;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        tick();
        checkOutput("reset_ready", {31'd0, cpu_ready}, 32'd0);
        checkOutput("reset_inst", cpu_inst, 32'd0);
        checkOutput("reset_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_adr", mem_adr, 32'd0);
        tick();
        rst = 1'b1;

        $display("[TB] basic fill of 0x40");
        checkMiss(32'h40);
        tick();
        serveRefill(32'h40, 0, -1, 32'h0, -1);
        checkHit(32'h40, 32'hA0);
        checkHit(32'h4C, 32'hA3);
        checkHit(32'h44, 32'hA1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack   = 1'b0;
        checkOutput("stray_ack_req", {31'd0, mem_req}, 32'd0);
        checkHit(32'h44, 32'hA1);

        $display("[TB] conflict miss with slow memory");
        checkMiss(32'h140);
        tick();
        serveRefill(32'h140, 2, -1, 32'h0, -1);
        checkHit(32'h140, 32'hE0);
        checkHit(32'h148, 32'hE2);
        checkMiss(32'h40);
        tick();
        serveRefill(32'h40, 0, -1, 32'h0, -1);
        checkHit(32'h40, 32'hA0);

        $display("[TB] flush in idle");
        applyStimulus(32'h40, 1'b1);
        tick();
        checkMiss(32'h40);

        $display("[TB] address change during refill");
        tick();
        serveRefill(32'h40, 0, 1, 32'h80, -1);
        checkMiss(32'h80);
        tick();
        serveRefill(32'h80, 1, -1, 32'h0, -1);
        checkHit(32'h80, 32'hB0);
        checkHit(32'h4C, 32'hA3);

        $display("[TB] flush during refill");
        checkMiss(32'hC0);
        tick();
        serveRefill(32'hC0, 0, -1, 32'h0, 2);
        checkMiss(32'h40);
        checkMiss(32'hC0);
        tick();
        checkOutput("refetch_req", {31'd0, mem_req}, 32'd1);
        checkOutput("refetch_adr", mem_adr, 32'hC0);
        serveRefill(32'hC0, 0, -1, 32'h0, -1);
        checkHit(32'hC4, 32'hC1);
        checkMiss(32'h100);
        tick();
        serveRefill(32'h100, 0, -1, 32'h0, 3);
        checkMiss(32'h100);
        checkMiss(32'hC4);

        $display("[TB] statistics and reset mid-refill");
        rst = 1'b0;
        #1;
        rst = 1'b1;
        checkMiss(32'h40);
        tick();
        serveRefill(32'h40, 0, -1, 32'h0, -1);
        for (int i = 0; i < 9; i++) begin
            checkHit(32'h40, 32'hA0);
            tick();
        end
        checkMiss(32'h140);
        tick();
        serveRefill(32'h140, 0, -1, 32'h0, -1);
`ifdef ICACHE_STATS_EN
        checkOutput("hit_cnt", hit_cnt, 32'd9);
        checkOutput("miss_cnt", miss_cnt, 32'd2);
`endif
        checkMiss(32'h40);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = mem_word(32'h40);
        tick();
        mem_ack   = 1'b0;
        checkOutput("mid_req", {31'd0, mem_req}, 32'd1);
        checkOutput("mid_adr", mem_adr, 32'h44);
        rst = 1'b0;
        #1;
        checkOutput("async_req", {31'd0, mem_req}, 32'd0);
        checkOutput("async_adr", mem_adr, 32'd0);
`ifdef ICACHE_STATS_EN
        checkOutput("async_hit_cnt", hit_cnt, 32'd0);
        checkOutput("async_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        rst = 1'b1;
        checkMiss(32'h40);
        checkMiss(32'h140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
